// File: rtl/rc_frame_scheduler.sv
// Frame scheduler for a bank of RC receiver readers: captures each channel's fresh
// width after its PWM falling edge, tracks signal loss and publishes coherent frames.
module rc_frame_scheduler #(
    parameter int                NUM_CH        = 4,
    parameter int                DATA_W        = 8,
    parameter int                SETTLE_CYCLES = 2,
    parameter int                TICK_DIV      = 208,
    parameter int                TIMEOUT_TICKS = 6400,
    parameter logic [DATA_W-1:0] FAILSAFE_VAL  = '0
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [NUM_CH-1:0]        pwm_in,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH*DATA_W-1:0] frame_data,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic [NUM_CH-1:0]        ch_lost,
    output logic                     failsafe,
    output logic                     frame_overrun
);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMR_W = $clog2(TIMEOUT_TICKS + 1);
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES);
    localparam logic [TMR_W-1:0] TIMEOUT_MAX = TMR_W'(TIMEOUT_TICKS);
    localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_DIV - 1);

    typedef enum logic {
        S_COLLECT,
        S_PUBLISH
    } state_t;

    state_t                        state_q, state_d;
    // sync1/sync2 form the synchroniser; sync3 is the previous synchronised value.
    logic [NUM_CH-1:0]             sync1_q, sync1_d;
    logic [NUM_CH-1:0]             sync2_q, sync2_d;
    logic [NUM_CH-1:0]             sync3_q, sync3_d;
    logic [NUM_CH-1:0][SET_W-1:0]  settle_q, settle_d;
    logic [NUM_CH-1:0][DATA_W-1:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0][TMR_W-1:0]  timer_q, timer_d;
    logic [NUM_CH-1:0]             cap_q, cap_d;
    logic [NUM_CH-1:0]             lost_q, lost_d;
    logic [PRE_W-1:0]              pre_q, pre_d;
    logic [NUM_CH*DATA_W-1:0]      frame_data_q, frame_data_d;
    logic                          frame_valid_q, frame_valid_d;
    logic                          overrun_q, overrun_d;
    logic                          failsafe_q, failsafe_d;

    logic [NUM_CH-1:0] rise, fall, capture, cap_base;
    logic              tick, launch, handshake, overrun_set;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d       = state_q;
        sync1_d       = pwm_in;
        sync2_d       = sync1_q;
        sync3_d       = sync2_q;
        settle_d      = settle_q;
        shadow_d      = shadow_q;
        timer_d       = timer_q;
        lost_d        = lost_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = frame_valid_q;
        overrun_set   = 1'b0;

        rise = sync2_q & ~sync3_q;
        fall = ~sync2_q & sync3_q;

        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : pre_q + PRE_W'(1);

        launch    = (state_q == S_COLLECT) && (&(cap_q | lost_q)) && (|cap_q);
        handshake = (state_q == S_PUBLISH) && frame_ready;

        cap_base = cap_q;
        if (launch) begin
            for (int i = 0; i < NUM_CH; i++) begin
                frame_data_d[i*DATA_W +: DATA_W] = cap_q[i] ? shadow_q[i] : FAILSAFE_VAL;
            end
            frame_valid_d = 1'b1;
            state_d       = S_PUBLISH;
            cap_base      = '0;
        end
        if (handshake) begin
            frame_valid_d = 1'b0;
            state_d       = S_COLLECT;
        end

        cap_d = cap_base;
        for (int i = 0; i < NUM_CH; i++) begin
            // A fresh fall restarts the settle window instead of completing the old one.
            capture[i] = (settle_q[i] == SET_W'(1)) && !fall[i];
            if (fall[i]) begin
                settle_d[i] = SETTLE_LOAD;
            end else if (settle_q[i] != '0) begin
                settle_d[i] = settle_q[i] - SET_W'(1);
            end

            if (capture[i]) begin
                shadow_d[i] = ch_data[i*DATA_W +: DATA_W];
                cap_d[i]    = 1'b1;
                if (cap_base[i]) begin
                    overrun_set = 1'b1;
                end
            end

            if (rise[i]) begin
                timer_d[i] = '0;
                lost_d[i]  = 1'b0;
            end else begin
                if (tick && (timer_q[i] != TIMEOUT_MAX)) begin
                    timer_d[i] = timer_q[i] + TMR_W'(1);
                end
                if (timer_q[i] == TIMEOUT_MAX) begin
                    lost_d[i] = 1'b1;
                    cap_d[i]  = 1'b0;
                end
            end
        end

        overrun_d  = overrun_set | (overrun_q & ~handshake);
        failsafe_d = |lost_d;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= S_COLLECT;
            sync1_q       <= '0;
            sync2_q       <= '0;
            sync3_q       <= '0;
            settle_q      <= '0;
            // NOTE: the shadow bank is tiny, so it is reset along with cap to leave no stale samples.
            shadow_q      <= '0;
            timer_q       <= '0;
            cap_q         <= '0;
            lost_q        <= '0;
            pre_q         <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            failsafe_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            sync3_q       <= sync3_d;
            settle_q      <= settle_d;
            shadow_q      <= shadow_d;
            timer_q       <= timer_d;
            cap_q         <= cap_d;
            lost_q        <= lost_d;
            pre_q         <= pre_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
            failsafe_q    <= failsafe_d;
        end
    end

    assign frame_data    = frame_data_q;
    assign frame_valid   = frame_valid_q;
    assign ch_lost       = lost_q;
    assign failsafe      = failsafe_q;
    assign frame_overrun = overrun_q;
endmodule

// File: tb/tb_rc_frame_scheduler.sv
// Bench for rc_frame_scheduler: scenario tasks check outputs against a per-channel
// model of the last width posted by each reader and the set of lost channels.
module tb_rc_frame_scheduler;
    localparam int DIV = 8;
    localparam int TO  = 40;

    logic        sys_clk     = 1'b0;
    logic        sys_rst_n   = 1'b0;
    logic [3:0]  pwm_in      = '0;
    logic [31:0] ch_data     = '0;
    logic        frame_ready = 1'b0;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic [3:0]  ch_lost;
    logic        failsafe;
    logic        frame_overrun;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [7:0]  exp_val [4];
    logic [3:0]  exp_lost = '0;

    always #5 sys_clk = ~sys_clk;

    rc_frame_scheduler #(
        .NUM_CH(4), .DATA_W(8), .SETTLE_CYCLES(2),
        .TICK_DIV(DIV), .TIMEOUT_TICKS(TO), .FAILSAFE_VAL(8'h00)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pwm_in(pwm_in), .ch_data(ch_data),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .ch_lost(ch_lost), .failsafe(failsafe), .frame_overrun(frame_overrun)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion want summary before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    function automatic logic [31:0] exp_frame();
        logic [31:0] f;
        for (int i = 0; i < 4; i++) f[i*8 +: 8] = exp_lost[i] ? 8'h00 : exp_val[i];
        return f;
    endfunction

    // Each selected channel goes high at its start offset and falls 4 cycles later,
    // at which moment its reader is modelled as posting the new width.
    task automatic pulse(input logic [3:0] mask, input logic [31:0] vals,
                         input logic [15:0] starts, input int len);
        int st;
        for (int c = 0; c < len; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) begin
                    st = int'(starts[i*4 +: 4]);
                    if (c == st) pwm_in[i] = 1'b1;
                    if (c == st + 4) begin
                        pwm_in[i]          = 1'b0;
                        ch_data[i*8 +: 8]  = vals[i*8 +: 8];
                        exp_val[i]         = vals[i*8 +: 8];
                    end
                end
            end
            tick();
        end
    endtask

    task automatic wait_valid(input string name, input int max);
        bit ok = 1'b0;
        for (int n = 0; n <= max; n++) begin
            if (frame_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL %s: got frame_valid=0 after %0d cycles want 1", name, max);
        end
    endtask

    task automatic check_frame(input string name);
        total++;
        if (frame_data !== exp_frame()) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, frame_data, exp_frame());
        end
    endtask

    task automatic consume(input string name);
        frame_ready = 1'b1;
        tick();
        total++;
        if (frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s: got frame_valid=%b want 0 after handshake", name, frame_valid);
        end
        frame_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit seen = 1'b0;
        sys_rst_n = 1'b0;
        for (int k = 0; k < 8; k++) begin
            pwm_in = 4'($urandom);
            tick();
        end
        total++;
        if ({frame_valid, frame_data, ch_lost, failsafe, frame_overrun} !== 39'h0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b d=%h l=%b f=%b o=%b want all 0",
                     frame_valid, frame_data, ch_lost, failsafe, frame_overrun);
        end
        pwm_in = '0;
        ticks(2);
        sys_rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (frame_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got frame_valid=1 want 0 with no captures");
        end
    endtask

    task automatic test_normal();
        logic [31:0] held;
        exp_lost = '0;
        pulse(4'hF, 32'h40302010, {4'd15, 4'd10, 4'd5, 4'd0}, 20);
        ticks(3);
        total++;
        if (frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL normal_early: got frame_valid=%b want 0", frame_valid);
        end
        ticks(2);
        total++;
        if (frame_valid !== 1'b1) begin
            bad++;
            $display("FAIL normal_valid: got frame_valid=%b want 1", frame_valid);
        end
        total++;
        if (frame_data !== 32'h40302010) begin
            bad++;
            $display("FAIL normal_data: got %h want 40302010", frame_data);
        end
        held = frame_data;
        ticks(3);
        total++;
        if (frame_valid !== 1'b1 || frame_data !== 32'h40302010) begin
            bad++;
            $display("FAIL normal_hold: got v=%b d=%h (was %h) want v=1 d=40302010",
                     frame_valid, frame_data, held);
        end
        consume("normal_hs");
    endtask

    task automatic test_backpressure();
        logic [31:0] saved;
        pulse(4'hF, $urandom, 16'($urandom), 24);
        wait_valid("bp_first_valid", 20);
        check_frame("bp_first_data");
        saved = exp_frame();
        pulse(4'b0010, 32'h0000_1100, 16'h0, 24);
        pulse(4'b1101, $urandom, 16'($urandom), 24);
        pulse(4'b0010, 32'h0000_5500, 16'h0, 24);
        ticks(2);
        total++;
        if (frame_valid !== 1'b1 || frame_data !== saved) begin
            bad++;
            $display("FAIL bp_hold: got v=%b d=%h want v=1 d=%h", frame_valid, frame_data, saved);
        end
        total++;
        if (frame_overrun !== 1'b1) begin
            bad++;
            $display("FAIL bp_overrun: got %b want 1", frame_overrun);
        end
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        total++;
        if (frame_valid !== 1'b0 || frame_overrun !== 1'b0) begin
            bad++;
            $display("FAIL bp_hs: got v=%b o=%b want v=0 o=0", frame_valid, frame_overrun);
        end
        tick();
        total++;
        if (frame_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_next_valid: got %b want 1", frame_valid);
        end
        check_frame("bp_next_data");
        total++;
        if (frame_data[15:8] !== 8'h55 || frame_overrun !== 1'b0) begin
            bad++;
            $display("FAIL bp_next_slice1: got s1=%h o=%b want s1=55 o=0",
                     frame_data[15:8], frame_overrun);
        end
        consume("bp_next_hs");
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            pulse(4'hF, $urandom, 16'($urandom), 24);
            wait_valid("rand_valid", 20);
            check_frame("rand_data");
            ticks($urandom_range(0, 5));
            total++;
            if (frame_valid !== 1'b1 || frame_data !== exp_frame() || frame_overrun !== 1'b0) begin
                bad++;
                $display("FAIL rand_hold: got v=%b d=%h o=%b want v=1 d=%h o=0",
                         frame_valid, frame_data, frame_overrun, exp_frame());
            end
            consume("rand_hs");
        end
    endtask

    task automatic test_settle();
        logic [7:0] y0, y3;
        pulse(4'b0110, $urandom, 16'h0, 24);
        pwm_in[0] = 1'b1;
        pwm_in[3] = 1'b1;
        ticks(4);
        pwm_in[0]      = 1'b0;
        pwm_in[3]      = 1'b0;
        ch_data[7:0]   = 8'hAA;
        ch_data[31:24] = 8'hAA;
        tick();
        y0 = 8'($urandom_range(0, 127));
        y3 = 8'($urandom_range(0, 127));
        ch_data[7:0]   = y0;
        ch_data[31:24] = y3;
        exp_val[0]     = y0;
        exp_val[3]     = y3;
        wait_valid("settle_valid", 20);
        check_frame("settle_data");
        ch_data[7:0]   = 8'hFF;
        ch_data[31:24] = 8'hFF;
        ticks(3);
        check_frame("settle_stable");
        consume("settle_hs");
    endtask

    task automatic test_reset_mid_frame();
        bit seen = 1'b0;
        pulse(4'hF, $urandom, 16'($urandom), 24);
        wait_valid("rstmid_valid", 20);
        pulse(4'b0001, $urandom, 16'h0, 24);
        sys_rst_n = 1'b0;
        #1;
        total++;
        if ({frame_valid, frame_data, ch_lost, failsafe, frame_overrun} !== 39'h0) begin
            bad++;
            $display("FAIL rstmid_outputs: got v=%b d=%h l=%b f=%b o=%b want all 0",
                     frame_valid, frame_data, ch_lost, failsafe, frame_overrun);
        end
        ticks(3);
        sys_rst_n = 1'b1;
        tick();
        pulse(4'b1110, $urandom, 16'($urandom), 24);
        for (int k = 0; k < 10; k++) begin
            if (frame_valid) seen = 1'b1;
            tick();
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_discard: got frame_valid=1 want 0 (ch0 sample not discarded)");
        end
        pulse(4'b0001, $urandom, 16'h0, 24);
        wait_valid("rstmid_after_valid", 20);
        check_frame("rstmid_after_data");
        consume("rstmid_hs");
    endtask

    task automatic test_loss();
        int t_r;
        exp_lost = '0;
        t_r = cyc;
        pulse(4'hF, $urandom, 16'h0, 24);
        wait_valid("loss_pre_valid", 20);
        check_frame("loss_pre_data");
        consume("loss_pre_hs");
        while (cyc < t_r + 100) tick();
        pulse(4'b1011, $urandom, 16'h0, 24);
        while (cyc < t_r + 200) tick();
        pulse(4'b1011, $urandom, 16'h0, 24);
        while (cyc < t_r + (TO - 2) * DIV) tick();
        total++;
        if (ch_lost !== 4'b0000 || frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL loss_early: got l=%b v=%b want l=0000 v=0", ch_lost, frame_valid);
        end
        while (cyc < t_r + (TO + 2) * DIV + 20) tick();
        exp_lost = 4'b0100;
        total++;
        if (ch_lost !== 4'b0100 || failsafe !== 1'b1) begin
            bad++;
            $display("FAIL loss_flag: got l=%b f=%b want l=0100 f=1", ch_lost, failsafe);
        end
        total++;
        if (frame_valid !== 1'b1 || frame_overrun !== 1'b1) begin
            bad++;
            $display("FAIL loss_frame: got v=%b o=%b want v=1 o=1", frame_valid, frame_overrun);
        end
        check_frame("loss_data");
        consume("loss_hs");
        pwm_in[2] = 1'b1;
        ticks(5);
        total++;
        if (ch_lost !== 4'b0000 || failsafe !== 1'b0) begin
            bad++;
            $display("FAIL loss_recover: got l=%b f=%b want l=0000 f=0", ch_lost, failsafe);
        end
        exp_lost = '0;
        pulse(4'hF, $urandom, 16'h0, 24);
        wait_valid("loss_rejoin_valid", 20);
        check_frame("loss_rejoin_data");
        consume("loss_rejoin_hs");
    endtask

    task automatic test_all_lost();
        bit seen = 1'b0;
        ticks(400);
        total++;
        if (ch_lost !== 4'hF || failsafe !== 1'b1 || frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL alllost_flags: got l=%b f=%b v=%b want l=1111 f=1 v=0",
                     ch_lost, failsafe, frame_valid);
        end
        for (int k = 0; k < 60; k++) begin
            tick();
            if (frame_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL alllost_no_frame: got frame_valid=1 want 0");
        end
        pwm_in = 4'hF;
        ticks(5);
        total++;
        if (ch_lost !== 4'h0 || failsafe !== 1'b0) begin
            bad++;
            $display("FAIL alllost_recover: got l=%b f=%b want l=0000 f=0", ch_lost, failsafe);
        end
        exp_lost = '0;
        pulse(4'hF, $urandom, 16'h0, 24);
        wait_valid("alllost_rejoin_valid", 20);
        check_frame("alllost_rejoin_data");
        consume("alllost_rejoin_hs");
    endtask

    initial begin
        for (int i = 0; i < 4; i++) exp_val[i] = '0;
        test_reset();
        test_normal();
        test_backpressure();
        test_random();
        test_settle();
        test_reset_mid_frame();
        test_loss();
        test_all_lost();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rc_frame_scheduler.md
Name: rc_frame_scheduler

Overview:
- Controller for a bank of NUM_CH reciever_reader instances, one per RC receiver channel.
- Watches each raw channel PWM line to know when its reader has posted a fresh 8-bit width, and captures that value after a settle delay.
- Detects per-channel signal loss and substitutes a failsafe value for lost channels.
- Publishes complete, coherent channel frames to the flight-control logic over a valid/ready handshake.

Parameters:
- NUM_CH, 4, number of receiver channels/reader instances.
- DATA_W, 8, width of each reader output.
- SETTLE_CYCLES, 2, sys_clk cycles from synchronised falling edge to capture of ch_data.
- TICK_DIV, 208, sys_clk cycles per timeout tick (256 ticks/ms, matching the reader's divider).
- TIMEOUT_TICKS, 6400, ticks with no rising edge before a channel is declared lost (25 ms).
- FAILSAFE_VAL, 0, value placed in the frame for a lost channel.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset; asynchronous, active-low.
- pwm_in  in  NUM_CH  raw receiver PWM lines, the same nets that drive the readers.
- ch_data  in  NUM_CH*DATA_W  concatenated reader outputs; channel i is at [i*DATA_W +: DATA_W].
- frame_data  out  NUM_CH*DATA_W  published frame, same packing as ch_data.
- frame_valid  out  1  frame_data holds an unconsumed frame.
- frame_ready  in  1  consumer accepts the frame.
- ch_lost  out  NUM_CH  per-channel loss flag.
- failsafe  out  1  OR of ch_lost.
- frame_overrun  out  1  sticky; set when any channel is recaptured before its previous sample was published. Cleared by a handshake.

Behaviour:
- Reset: all outputs 0; state COLLECT; all flags, timers and prescaler cleared.
- Reset mid-frame: any pending frame and captured samples are discarded.

Input conditioning:
- pwm_in passes through a 2-flop synchroniser per channel; edges are detected on the synchronised signal.
- Falling edge on channel i: start a settle counter. After SETTLE_CYCLES, copy ch_data slice i into shadow[i] and set cap[i].
- A new falling edge during settle restarts the count.
- Simultaneous edges on several channels are handled independently, in the same cycle.

Timeout:
- Prescaler emits a 1-cycle tick every TICK_DIV clocks.
- Per-channel timer clears on a synchronised rising edge and increments on each tick, saturating at TIMEOUT_TICKS.
- Reaching TIMEOUT_TICKS sets ch_lost[i] and clears cap[i].
- The next rising edge clears ch_lost[i] the following cycle. The channel then rejoins frames after its first capture.

Frame state machine:
- COLLECT:
  - When every channel has cap[i] or ch_lost[i] set, and at least one cap[i] is set, move to PUBLISH on the next cycle.
  - On that transition, frame_data slice i <= shadow[i] if cap[i], else FAILSAFE_VAL; clear all cap[]. frame_valid goes high in the same cycle the frame is loaded.
  - If all channels are lost, stay in COLLECT with frame_valid=0 and failsafe=1.
- PUBLISH:
  - frame_valid=1 and frame_data held stable until frame_valid && frame_ready.
  - On the handshake: frame_valid <= 0 next cycle, frame_overrun <= 0, return to COLLECT.
  - Captures arriving in PUBLISH update shadow/cap for the next frame.
  - If a channel with cap[i] already set is captured again (in either state), overwrite shadow[i] and set frame_overrun.
  - If a handshake and a recapture occur in the same cycle, set wins.
- Throughput:
  - Minimum one frame per 2 cycles after the all-captured condition.
  - Latency from last capture to frame_valid: 1 cycle.

Widths:
- Settle counter: clog2(SETTLE_CYCLES+1).
- Timer: clog2(TIMEOUT_TICKS+1).
- Prescaler: clog2(TICK_DIV).
- No arithmetic is performed on channel data.

Test Plan:
- Reset: hold sys_rst_n=0 with pwm_in toggling -> all outputs 0. Release -> no frame_valid until captures occur.
- Normal frame: drive ch_data={8'h40,8'h30,8'h20,8'h10} and drop pwm_in on all 4 channels, staggered by 5 cycles. The frame latches 2 cycles after the last fall, then frame_valid=1 1 cycle later with frame_data=0x40302010. Assert frame_ready 3 cycles later -> frame_valid=0 next cycle.
- Backpressure/overrun: hold frame_ready=0 and recapture ch1 with 8'h55 -> frame_data is unchanged and frame_overrun=1. After the handshake, the next frame carries 8'h55 in slice 1 and frame_overrun=0.
- Loss: stop ch2 edges for 6400 ticks -> ch_lost=4'b0100 and failsafe=1. The next frame has slice 2 = 8'h00. Restore ch2 -> ch_lost clears after its first rising edge.
- All lost: stop all channels -> ch_lost=4'hF, failsafe=1, and frame_valid stays 0 indefinitely.
- Settle/simultaneous: fall ch0 and ch3 in the same cycle and change ch_data 1 cycle after the fall -> the captured value is the one present SETTLE_CYCLES after the synchronised edge, for both channels.
